// File: rtl/pixel_mixer_if.sv
// LCD-side pixel stream of pixel_mixer: registered pixel with valid/ready,
// plus the per-line pixel position and end-of-line pulse.
interface pixel_mixer_if #(
  parameter int COLOR_W = 15
);
  logic [COLOR_W-1:0] pixel_out;
  logic               pixel_valid_out;
  logic               pixel_ready_in;
  logic [7:0]         x_out;
  logic               line_done_out;

  modport master (
    output pixel_out, pixel_valid_out, x_out, line_done_out,
    input  pixel_ready_in
  );

  modport slave (
    input  pixel_out, pixel_valid_out, x_out, line_done_out,
    output pixel_ready_in
  );
endinterface

// File: rtl/pixel_mixer.sv
// PPU pixel mixer: background FIFO with a head-aligned 8-slot sprite overlay,
// priority mixing, DMG/CGB colour resolution and BCPS/BCPD/OCPS/OCPD palette RAM.
module pixel_mixer #(
  parameter int DEPTH   = 16,
  parameter int COLOR_W = 15,
  parameter int X_MAX   = 160
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tclk_in,
  input  logic       cgb_mode_in,
  input  logic       line_start_in,
  input  logic [7:0] SCX_in,
  input  logic       bg_en_in,
  input  logic       obj_en_in,
  input  logic       bg_push_in,
  input  logic [7:0] bg_lo_in,
  input  logic [7:0] bg_hi_in,
  input  logic [7:0] bg_attr_in,
  output logic       bg_ready_out,
  input  logic       obj_push_in,
  input  logic [7:0] obj_lo_in,
  input  logic [7:0] obj_hi_in,
  input  logic [7:0] obj_attr_in,
  output logic       obj_ready_out,
  input  logic [7:0] BGP_in,
  input  logic [7:0] OBP0_in,
  input  logic [7:0] OBP1_in,
  input  logic       pal_sel_in,
  input  logic       pal_idx_wr_in,
  input  logic       pal_data_wr_in,
  input  logic [7:0] pal_wdata_in,
  output logic [7:0] pal_rdata_out,
  pixel_mixer_if.master lcd
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {logic prio; logic [2:0] pal; logic [1:0] color;} bg_px_t;
  typedef struct packed {logic [1:0] color; logic bgpri; logic dmgpal; logic [2:0] pal;} obj_px_t;

  bg_px_t             fifo_reg [DEPTH];
  bg_px_t             fifo_next [DEPTH];
  obj_px_t            slot_reg [8];
  obj_px_t            slot_next [8];
  logic [CW-1:0]      cnt_reg, cnt_next, base;
  logic [2:0]         discard_reg, discard_next;
  logic [7:0]         x_reg, x_next;
  logic               valid_reg, valid_next;
  logic [COLOR_W-1:0] pixel_reg, pixel_next, mixed;
  logic [7:0]         bg_ram [64];
  logic [7:0]         obj_ram [64];
  logic [6:0]         bg_idx_reg, obj_idx_reg, sel_idx, idx_next;

  bg_px_t  bg_row [8];
  obj_px_t obj_row [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      logic [1:0] bgc_raw, objc_raw;
      assign bgc_raw  = bg_attr_in[5]  ? {bg_hi_in[gi], bg_lo_in[gi]}   : {bg_hi_in[7-gi], bg_lo_in[7-gi]};
      assign objc_raw = obj_attr_in[5] ? {obj_hi_in[gi], obj_lo_in[gi]} : {obj_hi_in[7-gi], obj_lo_in[7-gi]};
      assign bg_row[gi]  = {bg_attr_in[7], bg_attr_in[2:0], bgc_raw};
      assign obj_row[gi] = {objc_raw, obj_attr_in[7], obj_attr_in[4], obj_attr_in[2:0]};
    end
  endgenerate

  logic       hs, pop;
  logic [8:0] produced;
  assign hs            = valid_reg & lcd.pixel_ready_in;
  // pixels already produced this line, including the one waiting in the output register
  assign produced      = {1'b0, x_reg} + {8'd0, valid_reg};
  assign pop           = tclk_in & (cnt_reg != '0) & (~valid_reg | lcd.pixel_ready_in)
                       & (produced < 9'(X_MAX)) & ~line_start_in;
  assign bg_ready_out  = int'(cnt_reg) <= DEPTH - 8;
  assign obj_ready_out = int'(cnt_reg) >= 8;

  bg_px_t     head;
  obj_px_t    spr;
  logic [1:0] bgc, col, shade;
  logic       obj_wins;
  logic [7:0] dmg_pal;
  logic [5:0] cgb_addr, cgb_addr_hi;
  logic [14:0] cgb_color;
  logic [COLOR_W+14:0] cgb_wide;

  assign head     = fifo_reg[0];
  assign spr      = slot_reg[0];
  assign bgc      = (bg_en_in | cgb_mode_in) ? head.color : 2'd0;
  assign obj_wins = obj_en_in & (spr.color != 2'd0)
                  & ~(spr.bgpri & (bgc != 2'd0))
                  & ~(cgb_mode_in & bg_en_in & head.prio & (bgc != 2'd0));
  assign col      = obj_wins ? spr.color : bgc;
  assign dmg_pal  = obj_wins ? (spr.dmgpal ? OBP1_in : OBP0_in) : BGP_in;
  assign shade    = dmg_pal[{col, 1'b0} +: 2];
  assign cgb_addr    = {obj_wins ? spr.pal : head.pal, col, 1'b0};
  assign cgb_addr_hi = cgb_addr | 6'd1;
  assign cgb_color   = obj_wins ? {obj_ram[cgb_addr_hi][6:0], obj_ram[cgb_addr]}
                                : {bg_ram[cgb_addr_hi][6:0], bg_ram[cgb_addr]};
  assign cgb_wide    = {{COLOR_W{1'b0}}, cgb_color};
  assign mixed       = cgb_mode_in ? cgb_wide[COLOR_W-1:0] : COLOR_W'(shade);

  always_comb begin
    fifo_next    = fifo_reg;
    slot_next    = slot_reg;
    cnt_next     = cnt_reg;
    discard_next = discard_reg;
    x_next       = x_reg;
    valid_next   = valid_reg;
    pixel_next   = pixel_reg;
    base         = cnt_reg - CW'(pop);
    if (line_start_in) begin
      for (int i = 0; i < DEPTH; i++) fifo_next[i] = '0;
      for (int i = 0; i < 8; i++) slot_next[i] = '0;
      cnt_next     = '0;
      discard_next = SCX_in[2:0];
      x_next       = 8'd0;
      valid_next   = 1'b0;
    end else begin
      if (hs) begin
        x_next     = x_reg + 8'd1;
        valid_next = 1'b0;
      end
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) fifo_next[i] = fifo_reg[i+1];
        fifo_next[DEPTH-1] = '0;
        for (int i = 0; i < 7; i++) slot_next[i] = slot_reg[i+1];
        slot_next[7] = '0;
        cnt_next     = cnt_reg - CW'(1);
        if (discard_reg != 3'd0) begin
          discard_next = discard_reg - 3'd1;
        end else begin
          valid_next = 1'b1;
          pixel_next = mixed;
        end
      end
      // the new row lands right behind whatever survives this cycle's pop
      if (bg_push_in && bg_ready_out) begin
        for (int i = 0; i < DEPTH; i++)
          if (i >= int'(base) && i < int'(base) + 8) fifo_next[i] = bg_row[3'(i - int'(base))];
        cnt_next = cnt_next + CW'(8);
      end
      if (obj_push_in && obj_ready_out) begin
        for (int i = 0; i < 8; i++)
          if (slot_next[i].color == 2'd0 && obj_row[i].color != 2'd0) slot_next[i] = obj_row[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) fifo_reg[i] <= '0;
      for (int i = 0; i < 8; i++) slot_reg[i] <= '0;
      cnt_reg     <= '0;
      discard_reg <= 3'd0;
      x_reg       <= 8'd0;
      valid_reg   <= 1'b0;
      pixel_reg   <= '0;
    end else begin
      fifo_reg    <= fifo_next;
      slot_reg    <= slot_next;
      cnt_reg     <= cnt_next;
      discard_reg <= discard_next;
      x_reg       <= x_next;
      valid_reg   <= valid_next;
      pixel_reg   <= pixel_next;
    end
  end

  assign sel_idx       = pal_sel_in ? obj_idx_reg : bg_idx_reg;
  assign pal_rdata_out = pal_sel_in ? obj_ram[sel_idx[5:0]] : bg_ram[sel_idx[5:0]];

  always_comb begin
    idx_next = sel_idx;
    if (pal_idx_wr_in)
      idx_next = {pal_wdata_in[7], pal_wdata_in[5:0]};
    else if (pal_data_wr_in && sel_idx[6])
      idx_next = {1'b1, sel_idx[5:0] + 6'd1};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 64; i++) begin
        bg_ram[i]  <= 8'd0;
        obj_ram[i] <= 8'd0;
      end
      bg_idx_reg  <= 7'd0;
      obj_idx_reg <= 7'd0;
    end else begin
      if (pal_data_wr_in) begin
        if (pal_sel_in) obj_ram[sel_idx[5:0]] <= pal_wdata_in;
        else            bg_ram[sel_idx[5:0]]  <= pal_wdata_in;
      end
      if (pal_sel_in) obj_idx_reg <= idx_next;
      else            bg_idx_reg  <= idx_next;
    end
  end

  assign lcd.pixel_out       = pixel_reg;
  assign lcd.pixel_valid_out = valid_reg;
  assign lcd.x_out           = x_reg;
  assign lcd.line_done_out   = hs & (x_reg == 8'(X_MAX - 1)) & ~line_start_in;

  logic unused_bits;
  assign unused_bits = ^{SCX_in[7:3], bg_attr_in[6], bg_attr_in[4:3],
                         obj_attr_in[6], obj_attr_in[3], pal_wdata_in[6]};
endmodule

// File: tb/tb_pixel_mixer.sv
// Directed plus randomized bench for pixel_mixer against a queue-based pixel model.
module tb_pixel_mixer;
  localparam int DEPTH = 16, COLOR_W = 15, X_MAX = 160;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tclk = 0, cgb = 0, line_start = 0, bg_en = 0, obj_en = 0;
  logic [7:0] scx = 0;
  logic bg_push = 0, obj_push = 0, bg_ready, obj_ready;
  logic [7:0] bg_lo = 0, bg_hi = 0, bg_attr = 0, obj_lo = 0, obj_hi = 0, obj_attr = 0;
  logic [7:0] bgp = 0, obp0 = 0, obp1 = 0;
  logic pal_sel = 0, pal_idx_wr = 0, pal_data_wr = 0;
  logic [7:0] pal_wdata = 0, pal_rdata;

  pixel_mixer_if #(.COLOR_W(COLOR_W)) lcd ();

  pixel_mixer #(.DEPTH(DEPTH), .COLOR_W(COLOR_W), .X_MAX(X_MAX)) dut (
    .clk_in(clk), .rst_in(rst_n), .tclk_in(tclk), .cgb_mode_in(cgb),
    .line_start_in(line_start), .SCX_in(scx), .bg_en_in(bg_en), .obj_en_in(obj_en),
    .bg_push_in(bg_push), .bg_lo_in(bg_lo), .bg_hi_in(bg_hi), .bg_attr_in(bg_attr),
    .bg_ready_out(bg_ready), .obj_push_in(obj_push), .obj_lo_in(obj_lo),
    .obj_hi_in(obj_hi), .obj_attr_in(obj_attr), .obj_ready_out(obj_ready),
    .BGP_in(bgp), .OBP0_in(obp0), .OBP1_in(obp1), .pal_sel_in(pal_sel),
    .pal_idx_wr_in(pal_idx_wr), .pal_data_wr_in(pal_data_wr), .pal_wdata_in(pal_wdata),
    .pal_rdata_out(pal_rdata), .lcd(lcd)
  );

  always #5 clk = ~clk;

  typedef struct {int color; int pal; int prio;} bgp_t;
  typedef struct {int color; int bgpri; int dmgpal; int pal;} spr_t;

  bgp_t q[$];
  spr_t spr[8];
  int m_discard, m_x, m_valid, m_pix;
  int ram[2][64];
  int idx_addr[2], idx_auto[2];
  int checks = 0, errors = 0, ld_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) spr[i] = '{0, 0, 0, 0};
    m_discard = 0; m_x = 0; m_valid = 0; m_pix = 0;
    for (int s = 0; s < 2; s++) begin
      idx_addr[s] = 0; idx_auto[s] = 0;
      for (int i = 0; i < 64; i++) ram[s][i] = 0;
    end
  endtask

  function automatic int model_pixel();
    int bgc, oc, win, c, p, a;
    bgc = (bg_en || cgb) ? q[0].color : 0;
    oc  = spr[0].color;
    win = (obj_en && oc != 0 && !(spr[0].bgpri != 0 && bgc != 0)
           && !(cgb && bg_en && q[0].prio != 0 && bgc != 0)) ? 1 : 0;
    c = win ? oc : bgc;
    if (!cgb) begin
      p = win ? (spr[0].dmgpal != 0 ? int'(obp1) : int'(obp0)) : int'(bgp);
      return (p >> (2 * c)) & 3;
    end
    a = (win ? spr[0].pal : q[0].pal) * 8 + c * 2;
    return (ram[win][a + 1] & 127) * 256 + ram[win][a];
  endfunction

  // Check current outputs against the model, then advance the model by one clock.
  task automatic cycle();
    int hs, pop, sz, pv, s, b;
    #1;
    hs = (m_valid != 0 && lcd.pixel_ready_in) ? 1 : 0;
    chk("valid", lcd.pixel_valid_out, m_valid);
    chk("pixel", lcd.pixel_out, m_pix);
    chk("x", lcd.x_out, m_x);
    chk("bg_ready", bg_ready, q.size() <= DEPTH - 8);
    chk("obj_ready", obj_ready, q.size() >= 8);
    chk("line_done", lcd.line_done_out, hs != 0 && m_x == X_MAX - 1 && !line_start);
    chk("rdata", pal_rdata, ram[pal_sel][idx_addr[pal_sel]]);
    if (lcd.line_done_out) ld_pulses++;
    if (hs != 0) $display("pixel x=%0d value=%0h", m_x, m_pix);
    sz = q.size();
    pv = 0;
    if (line_start) begin
      q.delete();
      for (int i = 0; i < 8; i++) spr[i] = '{0, 0, 0, 0};
      m_valid = 0; m_x = 0; m_discard = scx & 7;
    end else begin
      pop = (tclk && sz > 0 && (m_valid == 0 || lcd.pixel_ready_in) && m_x + m_valid < X_MAX) ? 1 : 0;
      if (pop != 0) pv = model_pixel();
      if (hs != 0) begin m_x++; m_valid = 0; end
      if (pop != 0) begin
        void'(q.pop_front());
        for (int i = 0; i < 7; i++) spr[i] = spr[i + 1];
        spr[7] = '{0, 0, 0, 0};
        if (m_discard > 0) m_discard--;
        else begin m_valid = 1; m_pix = pv; end
      end
      if (bg_push && sz <= DEPTH - 8)
        for (int i = 0; i < 8; i++) begin
          bgp_t e;
          b = bg_attr[5] ? i : 7 - i;
          e.color = 2 * int'(bg_hi[b]) + int'(bg_lo[b]);
          e.pal = int'(bg_attr[2:0]);
          e.prio = int'(bg_attr[7]);
          q.push_back(e);
        end
      if (obj_push && sz >= 8)
        for (int i = 0; i < 8; i++) begin
          int c;
          b = obj_attr[5] ? i : 7 - i;
          c = 2 * int'(obj_hi[b]) + int'(obj_lo[b]);
          if (spr[i].color == 0 && c != 0) begin
            spr[i].color = c; spr[i].bgpri = int'(obj_attr[7]);
            spr[i].dmgpal = int'(obj_attr[4]); spr[i].pal = int'(obj_attr[2:0]);
          end
        end
    end
    s = int'(pal_sel);
    if (pal_data_wr) ram[s][idx_addr[s]] = int'(pal_wdata);
    if (pal_idx_wr) begin
      idx_auto[s] = int'(pal_wdata[7]); idx_addr[s] = int'(pal_wdata) & 63;
    end else if (pal_data_wr && idx_auto[s] != 0) begin
      idx_addr[s] = (idx_addr[s] + 1) % 64;
    end
    @(negedge clk);
  endtask

  task automatic push_bg(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] attr);
    bg_lo = lo; bg_hi = hi; bg_attr = attr; bg_push = 1; cycle(); bg_push = 0;
  endtask

  task automatic push_obj(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] attr);
    obj_lo = lo; obj_hi = hi; obj_attr = attr; obj_push = 1; cycle(); obj_push = 0;
  endtask

  task automatic new_line(input logic [7:0] s);
    scx = s; line_start = 1; cycle(); line_start = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [COLOR_W-1:0] held;
    logic [7:0] hx;
    int n;
    lcd.pixel_ready_in = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", lcd.pixel_valid_out, 0);
    chk("rst_pixel", lcd.pixel_out, 0);
    chk("rst_x", lcd.x_out, 0);
    chk("rst_line_done", lcd.line_done_out, 0);
    chk("rst_bg_ready", bg_ready, 1);
    chk("rst_obj_ready", obj_ready, 0);
    chk("rst_rdata", pal_rdata, 0);
    @(negedge clk);
    rst_n = 1;

    // DMG row of colour 1 through BGP=E4
    bgp = 8'hE4; obp0 = 8'h04; obp1 = 8'hFC; bg_en = 1; obj_en = 1;
    new_line(8'd0);
    push_bg(8'hFF, 8'h00, 8'h00);
    tclk = 1; repeat (8) cycle(); tclk = 0;
    repeat (3) cycle();
    #1 chk("tp1_x", lcd.x_out, 8);

    // fine scroll discards the first three pixels
    new_line(8'd3);
    push_bg(8'h0F, 8'h33, 8'h00);
    push_bg(8'hAA, 8'h55, 8'h20);
    tclk = 1; n = 0;
    while (!lcd.pixel_valid_out && n < 10) begin cycle(); n++; end
    chk("scx_latency", n, 4);
    chk("scx_first", lcd.pixel_out, 2);
    repeat (14) cycle();
    tclk = 0; cycle();

    // sprite over bg colour 2: OBP0 shade, then BG-priority sprite
    new_line(8'd0);
    push_bg(8'h00, 8'h80, 8'h00);
    push_obj(8'h80, 8'h00, 8'h00);
    push_obj(8'h80, 8'h00, 8'h10);
    tclk = 1; cycle(); tclk = 0;
    chk("spr_obp0", lcd.pixel_out, 1);
    cycle();
    new_line(8'd0);
    push_bg(8'h00, 8'h80, 8'h00);
    push_obj(8'h80, 8'h00, 8'h80);
    tclk = 1; cycle(); tclk = 0;
    chk("spr_bgpri", lcd.pixel_out, 2);
    tclk = 1; repeat (8) cycle(); tclk = 0;

    // LCD stall holds the pixel and stops pops
    new_line(8'd0);
    push_bg(8'h5A, 8'hC3, 8'h00);
    tclk = 1; repeat (2) cycle();
    lcd.pixel_ready_in = 0;
    held = lcd.pixel_out; hx = lcd.x_out;
    repeat (5) cycle();
    chk("stall_hold", lcd.pixel_out, held);
    chk("stall_x", lcd.x_out, hx);
    lcd.pixel_ready_in = 1;
    repeat (8) cycle();
    tclk = 0;

    // CGB palette RAM with auto-increment
    cgb = 1; pal_sel = 0;
    pal_wdata = 8'h80; pal_idx_wr = 1; cycle(); pal_idx_wr = 0;
    pal_data_wr = 1;
    pal_wdata = 8'h1F; cycle();
    pal_wdata = 8'h7C; cycle();
    pal_wdata = 8'h33; cycle();
    pal_data_wr = 0;
    pal_wdata = 8'h02; pal_idx_wr = 1; cycle(); pal_idx_wr = 0;
    #1 chk("pal_idx2", pal_rdata, 8'h33);
    pal_wdata = 8'h01; pal_idx_wr = 1; cycle(); pal_idx_wr = 0;
    #1 chk("pal_idx1", pal_rdata, 8'h7C);
    new_line(8'd0);
    push_bg(8'h00, 8'h00, 8'h00);
    tclk = 1; cycle(); tclk = 0;
    chk("cgb_pixel", lcd.pixel_out, 15'h7C1F);

    // FIFO at DEPTH-7 refuses a push; then asynchronous reset mid-line
    new_line(8'd0);
    push_bg(8'h12, 8'h34, 8'h01);
    push_bg(8'h56, 8'h78, 8'h02);
    tclk = 1; repeat (7) cycle(); tclk = 0;
    #1 chk("full_bg_ready", bg_ready, 0);
    push_bg(8'hFF, 8'hFF, 8'h00);
    cycle();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", lcd.pixel_valid_out, 0);
    chk("mid_rst_pixel", lcd.pixel_out, 0);
    chk("mid_rst_x", lcd.x_out, 0);
    chk("mid_rst_line_done", lcd.line_done_out, 0);
    chk("mid_rst_obj_ready", obj_ready, 0);
    chk("mid_rst_rdata", pal_rdata, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // randomized full scanlines
    for (int ln = 0; ln < 3; ln++) begin
      int cyc;
      cgb = 1'($urandom); bg_en = 1'($urandom); obj_en = 1'($urandom);
      bgp = 8'($urandom); obp0 = 8'($urandom); obp1 = 8'($urandom);
      new_line(8'($urandom));
      ld_pulses = 0; cyc = 0;
      while (m_x < X_MAX && cyc < 3000) begin
        tclk = ($urandom % 4) != 0;
        lcd.pixel_ready_in = ($urandom % 5) != 0;
        bg_push = 1'($urandom); bg_lo = 8'($urandom); bg_hi = 8'($urandom); bg_attr = 8'($urandom);
        obj_push = ($urandom % 4) == 0; obj_lo = 8'($urandom); obj_hi = 8'($urandom);
        obj_attr = 8'($urandom);
        pal_sel = 1'($urandom); pal_data_wr = ($urandom % 8) == 0;
        pal_idx_wr = ($urandom % 16) == 0; pal_wdata = 8'($urandom);
        cycle();
        cyc++;
      end
      bg_push = 0; obj_push = 0; pal_data_wr = 0; pal_idx_wr = 0;
      lcd.pixel_ready_in = 1;
      chk("line_len", lcd.x_out, X_MAX);
      chk("line_done_pulses", ld_pulses, 1);
      tclk = 1; bg_push = 1;
      repeat (10) cycle();
      tclk = 0; bg_push = 0;
      chk("stop_after_line", lcd.pixel_valid_out, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_mixer.md
Name: pixel_mixer

Overview:
Parametrised successor to the PPU pixel FIFO stage. Holds a DEPTH-deep background pixel FIFO plus an 8-slot sprite overlay aligned to its head, and pops one pixel per T-cycle. Mixes background and sprite pixels by priority, resolves colour through DMG shade registers or CGB palette RAM, and streams pixels to the LCD with a valid/ready handshake.
Sits between the background/sprite fetchers and the LCD driver, and owns the BCPS/BCPD/OCPS/OCPD palette RAM.

Parameters:
DEPTH, 16, background FIFO depth in pixels; must be at least 16.
COLOR_W, 15, pixel_out width; must be at least 2.
X_MAX, 160, visible pixels per scanline.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
tclk_in  input  1  T-cycle enable; at most one pop per pulse
cgb_mode_in  input  1  1 = CGB palette RAM, 0 = DMG shade registers
line_start_in  input  1  start-of-scanline pulse
SCX_in  input  8  fine scroll; bits [2:0] used
bg_en_in  input  1  LCDC[0]
obj_en_in  input  1  LCDC[1]
bg_push_in  input  1  push one 8-pixel background row
bg_lo_in, bg_hi_in, bg_attr_in  input  8 each  tile planes and CGB attribute byte
bg_ready_out  output  1  FIFO count <= DEPTH-8
obj_push_in  input  1  merge one 8-pixel sprite row
obj_lo_in, obj_hi_in, obj_attr_in  input  8 each  sprite planes and OAM flags
obj_ready_out  output  1  FIFO count >= 8
BGP_in, OBP0_in, OBP1_in  input  8 each  DMG palettes
pal_sel_in  input  1  0 = BG palette RAM, 1 = OBJ palette RAM
pal_idx_wr_in  input  1  write index register (BCPS/OCPS)
pal_data_wr_in  input  1  write data register (BCPD/OCPD)
pal_wdata_in  input  8  data for index or data write
pal_rdata_out  output  8  byte at the selected RAM's current index
pixel_out  output  COLOR_W  resolved colour
pixel_valid_out  output  1  pixel_out valid
pixel_ready_in  input  1  LCD accepts pixel
x_out  output  8  pixels emitted on this line
line_done_out  output  1  one-cycle pulse on the X_MAX-th handshake

Behaviour:
- Reset (rst_in low, asynchronous): FIFO and sprite slots empty; discard count, x_out, both palette indices and pixel_valid_out are 0; pixel_out is 0; line_done_out is 0; palette RAM contents are 0.
- Background row expansion: pixel i (i = 0..7) = {hi[7-i], lo[7-i]}. If attr[5] (xflip) is set, use {hi[i], lo[i]}. Each pixel stores its 2-bit colour, attr[2:0] as palette, and attr[7] as priority.
- bg_push_in while bg_ready_out is 0: the push is ignored and the FIFO is unchanged.
- Sprite merge: obj_push_in while obj_ready_out is 1 overlays sprite slots 0..7, with slot 0 aligned to the FIFO head.
  - A slot is replaced only when its current colour is 0 and the new colour is non-zero, so the earlier sprite wins.
  - Each slot stores attr[7] (BG priority), attr[4] (DMG palette) and attr[2:0] (CGB palette). attr[5] flips the row as above.
  - obj_push_in while obj_ready_out is 0 is ignored.
- Pop condition: tclk_in, count > 0, and the output register is free (pixel_valid_out is 0, or pixel_ready_in is 1).
  - A pop shifts the sprite slots; slot 7 is refilled with colour 0.
  - A push and a pop in the same cycle are both applied: count changes by +8-1.
- Discard phase: while the discard count is non-zero, a pop drops the pixel, decrements the count, and emits nothing.
- Mixing:
  - bgc = bg colour, forced to 0 when bg_en_in is 0 in DMG mode.
  - The sprite wins when obj_en_in is 1, objc is non-zero, and none of these hold:
    - sprite BG-priority is set and bgc is non-zero;
    - CGB mode, bg_en_in is 1, the BG attr priority bit is set, and bgc is non-zero.
- Colour resolution:
  - DMG: shade = palette >> (2 * colour), where palette is BGP_in, OBP0_in or OBP1_in. pixel_out = zero-extended 2-bit shade.
  - CGB: byte address = palette*8 + colour*2 within the selected RAM (BG or OBJ). pixel_out = {byte[addr+1][6:0], byte[addr]}, zero-extended or truncated to COLOR_W.
- Latency: the pop cycle registers the result, so pixel_valid_out rises on the next cycle. pixel_out is held stable while valid and not ready. pixel_valid_out clears after a handshake with no new pop.
- x_out increments on each handshake. line_done_out pulses on the cycle of the X_MAX-th handshake. Pops stop after X_MAX pixels until the next line_start_in.
- line_start_in takes priority over everything else except reset:
  - clears the FIFO, sprite slots, output valid and x_out;
  - loads the discard count with SCX_in[2:0];
  - drops any same-cycle push or pop.
- Palette RAM: two 64-byte arrays, each with a 7-bit index register. Index bit 7 = auto-increment enable; bits 5:0 = address.
  - A data write stores the byte at the selected RAM's index, then adds 1 to bits 5:0 (wrapping 63 to 0) if auto-increment is set.
  - A simultaneous index write and data write: the data goes to the old index, then the index loads pal_wdata_in.
  - pal_rdata_out is combinational from the selected RAM and index.
  - Writes are visible to pixels popped on the following cycle.

Test Plan:
- DMG, BGP=0xE4, push lo=0xFF, hi=0x00, SCX=0, 8 tclk pulses, ready=1 -> eight pixels of value 1, x_out=8.
- SCX=3, line_start, push two rows -> first 3 pops produce no output; the 1st emitted pixel is row-1 pixel 3, one cycle after its pop.
- Sprite lo=0x80, attr=0x00 onto bg colour 2 -> pixel 0 is the OBP0 shade of colour 1. With attr=0x80 -> BG shade. A 2nd sprite on the same slot -> ignored.
- pixel_ready_in low for 5 cycles with tclk pulsing -> pixel_out held, no pops, count unchanged; resumes in order when ready rises.
- CGB: idx write 0x80, data writes 0x1F, 0x7C -> BG palette 0 colour 0 = 0x7C1F, index = 2. A bg colour-0 pixel outputs 0x7C1F.
- Fill the FIFO to DEPTH-7 -> bg_ready_out=0, extra push ignored. Assert rst_in low mid-line -> all outputs 0 immediately.
